lcd_hex_display: RTL

- Drives the DE2 16x2 character LCD (HD44780-compatible, 8-bit bus, write-only) from a 32-bit debug word.
- Shows the word as 8 uppercase hex digits on line 1, MSB first.
- Sits downstream of the top-level debug taps: consumes lcd_write_en/lcd_write_data and owns the lcd_* pins.
- Runs the power-up init sequence itself, then refreshes line 1 whenever new data has been written.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_bus_cycle.sv | 119 +++++++++++
 rtl/lcd_hex_display.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 hex display.
//   - command byte constants for the 8-bit interface
//   - sequencer state and bus phase enums
//   - hex_to_ascii: nibble to uppercase ASCII hex digit
//   - init_cmd: byte for each step of the power-up sequence
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off, no blink
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display, needs the long wait
  localparam logic [7:0] LCD_ADDR_L1  = 8'h80;  // DDRAM address 0 (line 1, column 0)

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR
  } lcd_state_t;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_EN_HI,
    BUS_HOLD,
    BUS_WAIT
  } bus_phase_t;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle: one write transfer on the HD44780 bus.
//   SETUP (1 cycle) -> EN_HI (T_EN cycles) -> HOLD (1 cycle) -> WAIT.
//   WAIT lasts T_CLEAR cycles when long_wait was set at start, else T_CMD.
// Ports:
//   clk_in, reset_n       clock, asynchronous active-low reset
//   start, rs, data       request a transfer; sampled when idle or on done
//   long_wait             use the clear-command wait length
//   lcd_en/lcd_rs/lcd_data  registered bus pins
//   done                  one-cycle pulse in the last WAIT cycle
// A start presented together with done chains the next transfer with no
// idle cycle in between.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int T_EN    = 16,
  parameter int T_CMD   = 2_500,
  parameter int T_CLEAR = 100_000
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam int WAIT_MAX = (T_CLEAR > T_CMD) ? T_CLEAR : T_CMD;
  localparam int CNT_MAX  = (WAIT_MAX > T_EN) ? WAIT_MAX : T_EN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  bus_phase_t       r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_wait_last;
  logic             r_long, r_en, r_rs;
  logic [7:0]       r_data;
  logic             w_load;

  assign w_wait_last = r_long ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    done        = 1'b0;
    case (r_phase)
      BUS_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_phase_nxt = BUS_SETUP;
        end
      end
      BUS_SETUP: begin
        w_phase_nxt = BUS_EN_HI;
        w_cnt_nxt   = '0;
      end
      BUS_EN_HI: begin
        if (r_cnt == CNT_W'(T_EN - 1)) begin
          w_phase_nxt = BUS_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      BUS_HOLD: begin
        w_phase_nxt = BUS_WAIT;
        w_cnt_nxt   = '0;
      end
      BUS_WAIT: begin
        if (r_cnt == w_wait_last) begin
          done = 1'b1;
          if (start) begin
            w_load      = 1'b1;
            w_phase_nxt = BUS_SETUP;
          end else begin
            w_phase_nxt = BUS_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_phase_nxt = BUS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= BUS_IDLE;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      // Enable is registered from the next phase so the pin is glitch-free.
      r_en    <= (w_phase_nxt == BUS_EN_HI);
      // rs/data only move on the load edge, i.e. when SETUP begins.
      if (w_load) begin
        r_rs   <= rs;
        r_data <= data;
        r_long <= long_wait;
      end
    end
  end

  assign lcd_en   = r_en;
  assign lcd_rs   = r_rs;
  assign lcd_data = r_data;

endmodule

// File: rtl/lcd_hex_display.sv
// lcd_hex_display: shows a 32-bit word as 8 uppercase hex digits on line 1
// of an HD44780 16x2 LCD (8-bit, write-only bus).
// Ports:
//   clk_in, reset_n        50 MHz clock, asynchronous active-low reset
//   write_en, write_data   capture a new word (last write wins)
//   lcd_data/lcd_rs/lcd_en LCD bus; lcd_rw tied low
//   lcd_on, lcd_blon       panel power and backlight, always on
//   ready                  init sequence complete
// The word being drawn is frozen in r_shown at frame start; writes during a
// frame only update r_pending and mark a follow-up frame as needed.
module lcd_hex_display
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 1_000_000,
  parameter int T_EN      = 16,
  parameter int T_CMD     = 2_500,
  parameter int T_CLEAR   = 100_000
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        write_en,
  input  logic [31:0] write_data,
  output logic [7:0]  lcd_data,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        ready
);

  localparam int PWR_W = $clog2(T_POWERUP + 1);

  lcd_state_t       r_state, w_state_nxt;
  logic [PWR_W-1:0] r_timer, w_timer_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [31:0]      r_pending, r_shown;
  logic             r_dirty, r_ready;

  logic             w_start, w_rs, w_long, w_done, w_take, w_ready_set;
  logic [7:0]       w_data;
  logic [2:0]       w_char_idx;
  logic [3:0]       w_nibble;

  // Digit mux: next character is digit 0 when leaving ADDR, else idx+1.
  // Digit k sits at bits [31-4k -: 4]; for 3-bit k, 7-k == ~k.
  assign w_char_idx = (r_state == ST_CHAR) ? (r_idx + 3'd1) : 3'd0;
  assign w_nibble   = r_shown[{~w_char_idx, 2'b00} +: 4];

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_start     = 1'b0;
    w_rs        = 1'b0;
    w_data      = 8'h00;
    w_take      = 1'b0;
    w_ready_set = 1'b0;
    case (r_state)
      ST_PWRUP: begin
        if (r_timer == PWR_W'(T_POWERUP - 1)) begin
          w_state_nxt = ST_INIT;
          w_idx_nxt   = 3'd0;
          w_start     = 1'b1;
          w_data      = init_cmd(2'd0);
        end else begin
          w_timer_nxt = r_timer + PWR_W'(1);
        end
      end
      ST_INIT: begin
        if (w_done) begin
          if (r_idx == 3'd3) begin
            w_ready_set = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_start   = 1'b1;
            w_data    = init_cmd(r_idx[1:0] + 2'd1);
          end
        end
      end
      ST_IDLE: begin
        if (r_dirty) begin
          w_take      = 1'b1;
          w_state_nxt = ST_ADDR;
          w_start     = 1'b1;
          w_data      = LCD_ADDR_L1;
        end
      end
      ST_ADDR: begin
        if (w_done) begin
          w_state_nxt = ST_CHAR;
          w_idx_nxt   = 3'd0;
          w_start     = 1'b1;
          w_rs        = 1'b1;
          w_data      = hex_to_ascii(w_nibble);
        end
      end
      ST_CHAR: begin
        if (w_done) begin
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_start   = 1'b1;
            w_rs      = 1'b1;
            w_data    = hex_to_ascii(w_nibble);
          end
        end
      end
      default: w_state_nxt = ST_PWRUP;
    endcase
  end

  // Only the clear command needs the long post-transfer wait.
  assign w_long = !w_rs && (w_data == LCD_CLEAR);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_PWRUP;
      r_timer   <= '0;
      r_idx     <= 3'd0;
      r_pending <= 32'h0;
      r_shown   <= 32'h0;
      r_dirty   <= 1'b1;  // forces one frame of zeros after init
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      if (w_ready_set) r_ready <= 1'b1;
      if (w_take)      r_shown <= r_pending;
      // A write in the same cycle as frame start keeps dirty set so the
      // newer word gets its own frame.
      if (write_en) begin
        r_pending <= write_data;
        r_dirty   <= 1'b1;
      end else if (w_take) begin
        r_dirty <= 1'b0;
      end
    end
  end

  lcd_bus_cycle #(
    .T_EN    (T_EN),
    .T_CMD   (T_CMD),
    .T_CLEAR (T_CLEAR)
  ) u_bus (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .start     (w_start),
    .rs        (w_rs),
    .data      (w_data),
    .long_wait (w_long),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .done      (w_done)
  );

  assign ready    = r_ready;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;

endmodule
